// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, coordinate type and axis-length helper for the
// scan controller and its per-axis counters.
package vga_timing_pkg;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;
  localparam int unsigned DEF_CLK_DIV   = 2;

  localparam int unsigned COORD_LIMIT   = 1024;

  typedef logic [9:0] coord_t;

  function automatic int unsigned axis_total(input int unsigned visible,
                                             input int unsigned front,
                                             input int unsigned sync,
                                             input int unsigned back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered sync/active
// decodes, so every output changes on the same edge as the count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned FRONT   = DEF_H_FRONT,
  parameter int unsigned SYNC    = DEF_H_SYNC,
  parameter int unsigned BACK    = DEF_H_BACK
) (
  input  logic   Clk,
  input  logic   Reset,
  input  logic   advance,
  output coord_t count,
  output logic   sync_n,
  output logic   active,
  output logic   at_last
);

  localparam int unsigned TOTAL = axis_total(VISIBLE, FRONT, SYNC, BACK);
  localparam coord_t LAST    = coord_t'(TOTAL - 1);
  localparam coord_t SYNC_LO = coord_t'(VISIBLE + FRONT);
  localparam coord_t SYNC_HI = coord_t'(VISIBLE + FRONT + SYNC - 1);
  localparam coord_t VIS     = coord_t'(VISIBLE);

  coord_t count_q, count_d;
  logic   sync_n_q, sync_n_d;
  logic   active_q, active_d;

  assign at_last = (count_q == LAST);

  // Decodes are taken from the next count so they land with it.
  always_comb begin
    count_d = count_q;
    if (advance) count_d = at_last ? '0 : count_q + coord_t'(1);
    sync_n_d = !((count_d >= SYNC_LO) && (count_d <= SYNC_HI));
    active_d = (count_d < VIS);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q  <= '0;
      sync_n_q <= 1'b1;
      active_q <= 1'b1;
    end else begin
      count_q  <= count_d;
      sync_n_q <= sync_n_d;
      active_q <= active_d;
    end
  end

  assign count  = count_q;
  assign sync_n = sync_n_q;
  assign active = active_q;

endmodule

// File: rtl/vga_scan_controller.sv
// Raster scan generator: pixel clock-enable divider plus horizontal/vertical
// axis counters, producing DrawX/DrawY, hs, vs, blank and frame_start.
module vga_scan_controller
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV
) (
  input  logic   Clk,
  input  logic   Reset,
  output logic   pixel_ce,
  output coord_t DrawX,
  output coord_t DrawY,
  output logic   hs,
  output logic   vs,
  output logic   blank,
  output logic   frame_start
);

  localparam int unsigned H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT) begin : g_bad_total
    $error("vga_scan_controller: H_TOTAL/V_TOTAL exceed 10-bit coordinate range");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_scan_controller: CLK_DIV must be at least 1");
  end

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic h_at_last, v_at_last, h_active, v_active;

  // With CLK_DIV=1 the counter is stuck at 0 and pixel_ce stays high.
  assign pixel_ce = (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d = pixel_ce ? '0 : div_cnt_q + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) div_cnt_q <= '0;
    else       div_cnt_q <= div_cnt_d;
  end

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
  ) u_h (
    .Clk(Clk), .Reset(Reset), .advance(pixel_ce),
    .count(DrawX), .sync_n(hs), .active(h_active), .at_last(h_at_last)
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
  ) u_v (
    .Clk(Clk), .Reset(Reset), .advance(pixel_ce & h_at_last),
    .count(DrawY), .sync_n(vs), .active(v_active), .at_last(v_at_last)
  );

  assign blank       = h_active & v_active;
  assign frame_start = pixel_ce & h_at_last & v_at_last;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller: a closed-form timing model pushes the expected
// outputs per edge; a negedge monitor pops and compares, plus directed checks.
module tb_vga_scan_controller;

  typedef struct packed {
    logic       ce;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       bl;
    logic       fs;
  } obs_t;

  logic Clk = 1'b0;
  logic rst_d = 1'b1, rst_s = 1'b1, rst_1 = 1'b1;
  always #5 Clk = ~Clk;

  logic       ce_d, hs_d, vs_d, bl_d, fs_d;
  logic [9:0] x_d, y_d;
  logic       ce_s, hs_s, vs_s, bl_s, fs_s;
  logic [9:0] x_s, y_s;
  logic       ce_1, hs_1, vs_1, bl_1, fs_1;
  logic [9:0] x_1, y_1;

  // default 640x480 timing, CLK_DIV=2
  vga_scan_controller dut_d (
    .Clk(Clk), .Reset(rst_d), .pixel_ce(ce_d), .DrawX(x_d), .DrawY(y_d),
    .hs(hs_d), .vs(vs_d), .blank(bl_d), .frame_start(fs_d));

  // small raster: H 8/2/3/3 = 16, V 4/1/2/1 = 8, CLK_DIV=2 -> 256 Clk frame
  vga_scan_controller #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .CLK_DIV(2)
  ) dut_s (
    .Clk(Clk), .Reset(rst_s), .pixel_ce(ce_s), .DrawX(x_s), .DrawY(y_s),
    .hs(hs_s), .vs(vs_s), .blank(bl_s), .frame_start(fs_s));

  // same small raster with CLK_DIV=1 -> 128 Clk frame
  vga_scan_controller #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .CLK_DIV(1)
  ) dut_1 (
    .Clk(Clk), .Reset(rst_1), .pixel_ce(ce_1), .DrawX(x_1), .DrawY(y_1),
    .hs(hs_1), .vs(vs_1), .blank(bl_1), .frame_start(fs_1));

  obs_t obs_d, obs_s, obs_1;
  assign obs_d = {ce_d, x_d, y_d, hs_d, vs_d, bl_d, fs_d};
  assign obs_s = {ce_s, x_s, y_s, hs_s, vs_s, bl_s, fs_s};
  assign obs_1 = {ce_1, x_1, y_1, hs_1, vs_1, bl_1, fs_1};

  // Expected outputs n Clk edges after the reset edge, from raster arithmetic.
  function automatic obs_t model(input int n, input int hv, input int hf,
                                 input int hsy, input int hb, input int vv,
                                 input int vf, input int vsy, input int vb,
                                 input int div);
    obs_t m;
    int ht, vt, px, x, y;
    ht = hv + hf + hsy + hb;
    vt = vv + vf + vsy + vb;
    px = n / div;
    x  = px % ht;
    y  = (px / ht) % vt;
    m.ce = ((n % div) == div - 1);
    m.x  = 10'(x);
    m.y  = 10'(y);
    m.hs = !(x >= hv + hf && x < hv + hf + hsy);
    m.vs = !(y >= vv + vf && y < vv + vf + vsy);
    m.bl = (x < hv) && (y < vv);
    m.fs = m.ce && (x == ht - 1) && (y == vt - 1);
    return m;
  endfunction

  obs_t q_d[$], q_s[$], q_1[$];
  int   n_d = 0, n_s = 0, n_1 = 0;

  always @(posedge Clk) begin
    int nd, ns, n1;
    nd = rst_d ? 0 : n_d + 1;
    ns = rst_s ? 0 : n_s + 1;
    n1 = rst_1 ? 0 : n_1 + 1;
    n_d <= nd;
    n_s <= ns;
    n_1 <= n1;
    q_d.push_back(model(nd, 640, 16, 96, 48, 480, 10, 2, 33, 2));
    q_s.push_back(model(ns, 8, 2, 3, 3, 4, 1, 2, 1, 2));
    q_1.push_back(model(n1, 8, 2, 3, 3, 4, 1, 2, 1, 1));
  end

  int n_cmp = 0, n_bad = 0, n_prt = 0;
  int cyc = 0;
  bit done = 1'b0;

  task automatic sb_check(input string nm, input obs_t e, input obs_t a);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      if (n_prt < 40) begin
        n_prt++;
        $display("FAIL scan_%s cyc=%0d got x=%0d y=%0d ce/hs/vs/bl/fs=%b%b%b%b%b want x=%0d y=%0d ce/hs/vs/bl/fs=%b%b%b%b%b",
                 nm, cyc, a.x, a.y, a.ce, a.hs, a.vs, a.bl, a.fs,
                 e.x, e.y, e.ce, e.hs, e.vs, e.bl, e.fs);
      end
    end
  endtask

  task automatic chk(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      if (n_prt < 40) begin
        n_prt++;
        $display("FAIL %s cyc=%0d got %0d want %0d", nm, cyc, got, want);
      end
    end
  endtask

  // directed-check state
  bit         pv_d = 1'b0;
  logic       p_hs_d, p_bl_d;
  logic [9:0] p_x_d, p_y_d;
  int hs_low_y1 = 0, bl_low_y1 = 0, hs_falls = 0, line_wraps = 0;
  int vs_low_s = 0, last_fs_s = -1, fs_cnt_s = 0;
  int last_fs_1 = -1, fs_cnt_1 = 0;

  always @(negedge Clk) begin
    cyc <= cyc + 1;
    if (q_d.size() > 0) sb_check("d", q_d.pop_front(), obs_d);
    if (q_s.size() > 0) sb_check("s", q_s.pop_front(), obs_s);
    if (q_1.size() > 0) sb_check("1", q_1.pop_front(), obs_1);

    // default raster: edges of hs/blank at hand-computed columns, line wrap
    if (!rst_d) begin
      if (pv_d) begin
        if (p_hs_d && !hs_d) begin chk("hs_fall_x", int'(x_d), 656); hs_falls++; end
        if (!p_hs_d && hs_d) chk("hs_rise_x", int'(x_d), 752);
        if (p_bl_d && !bl_d) chk("blank_fall_x", int'(x_d), 640);
        if (!p_bl_d && bl_d) chk("blank_rise_x", int'(x_d), 0);
        if (p_x_d == 10'd799 && x_d == 10'd0) begin
          chk("line_wrap_y", int'(y_d), int'(p_y_d) + 1);
          line_wraps++;
        end
      end
      if (y_d == 10'd1 && !hs_d) hs_low_y1++;
      if (y_d == 10'd1 && !bl_d) bl_low_y1++;
      pv_d = 1'b1;
    end
    p_hs_d = hs_d; p_bl_d = bl_d; p_x_d = x_d; p_y_d = y_d;

    // small raster, CLK_DIV=2: frame period 256, vs low 2 lines * 16 * 2 = 64
    if (rst_s) begin
      vs_low_s = 0;
      last_fs_s = -1;
    end else begin
      if (!vs_s) vs_low_s++;
      if (fs_s) begin
        chk("vs_low_per_frame_s", vs_low_s, 64);
        if (last_fs_s >= 0) chk("frame_period_s", cyc - last_fs_s, 256);
        last_fs_s = cyc;
        vs_low_s = 0;
        fs_cnt_s++;
      end
    end

    // small raster, CLK_DIV=1: frame period 128
    if (!rst_1 && fs_1) begin
      if (last_fs_1 >= 0) chk("frame_period_1", cyc - last_fs_1, 128);
      last_fs_1 = cyc;
      fs_cnt_1++;
    end

    if (cyc == 6200) begin
      chk("hs_low_clk_line1", hs_low_y1, 192);
      chk("blank_low_clk_line1", bl_low_y1, 320);
      chk("hs_falls_ge3", int'(hs_falls >= 3), 1);
      chk("line_wraps_ge3", int'(line_wraps >= 3), 1);
      chk("frames_s_ge10", int'(fs_cnt_s >= 10), 1);
      chk("frames_1_ge20", int'(fs_cnt_1 >= 20), 1);
      done = 1'b1;
    end
  end

  initial begin
    repeat (3) @(negedge Clk);
    #2;
    rst_d = 1'b0;
    rst_s = 1'b0;
    rst_1 = 1'b0;
    // mid-frame reset on the small raster (x=6, y=2 territory)
    repeat (1100) @(negedge Clk);
    #2 rst_s = 1'b1;
    @(negedge Clk);
    #2 rst_s = 1'b0;
    wait (done);
    @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_scan_controller.md
# vga_scan_controller

- Generates the raster scan that drives the pixel pipeline: the DrawX/DrawY coordinates consumed by the colour mapping logic, plus hs, vs, a blanking flag, a pixel clock enable and a per-frame pulse.
- Default timing is 640×480 @ 60 Hz on the 50 MHz system clock, with a divide-by-2 pixel enable.
- Sits between the board clock and the VGA DAC; the game/ball logic uses frame_start as its once-per-frame update strobe.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 2, Clk cycles per pixel (≥1)

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- pixel_ce  out  1  high one Clk in every CLK_DIV
- DrawX  out  10  current pixel column, 0..H_TOTAL-1
- DrawY  out  10  current line, 0..V_TOTAL-1
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- blank  out  1  active low; 1 = visible pixel, 0 = blanking
- frame_start  out  1  one-Clk pulse on the last Clk of each frame

## Operation
- Derived totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525). Both totals must be ≤1024; elaboration fails otherwise.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pixel_ce = (div_cnt == CLK_DIV-1). With CLK_DIV=1, pixel_ce is constantly 1.
- Horizontal counter: advances on the edge ending a pixel_ce cycle. It wraps H_TOTAL-1→0, and the vertical counter advances on that same edge.
- Vertical counter: wraps V_TOTAL-1→0.
- DrawX/DrawY are the counters. They keep counting through blanking and are never clamped.
- Decodes, registered in the same edge as the counters so that all outputs describe the same pixel:
  - hs = 0 iff DrawX ∈ [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (656..751)
  - vs = 0 iff DrawY ∈ [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (490..491)
  - blank = 1 iff DrawX < H_VISIBLE and DrawY < V_VISIBLE
- frame_start = pixel_ce && DrawX == H_TOTAL-1 && DrawY == V_TOTAL-1. It is high exactly once per frame, in the cycle before the wrap to (0,0).
- Reset values: div_cnt 0, DrawX 0, DrawY 0, hs 1, vs 1, blank 1, pixel_ce 0 (1 if CLK_DIV=1), frame_start 0.
- Reset mid-frame: the next edge forces the reset values regardless of pixel_ce or counter state. There is no partial-frame frame_start.
- Simultaneous line and frame wrap: both counters return to 0 on the same edge; DrawY is never observed at V_TOTAL.

## Timing
- All outputs except pixel_ce and frame_start are flops. pixel_ce and frame_start are single-level decodes of flops, with no input-to-output combinational path.
- Each (DrawX, DrawY) value, with its hs/vs/blank, is held for exactly CLK_DIV Clk cycles.
- This includes pixel (0,0) after Reset deasserts: with CLK_DIV=2, pixel_ce is first high in Clk 1 and DrawX becomes 1 at the end of Clk 1.
- Line period: H_TOTAL·CLK_DIV = 1600 Clk. Frame period: H_TOTAL·V_TOTAL·CLK_DIV = 840000 Clk.
- hs low for H_SYNC·CLK_DIV = 192 Clk per line. vs low for V_SYNC·H_TOTAL·CLK_DIV = 3200 Clk per frame.

## Structure
- Package vga_timing_pkg holds:
  - default timing constants (the 640×480 set)
  - the H_TOTAL/V_TOTAL derivation function
  - the 10-bit coordinate typedef
- One sub-module, vga_axis_counter, is instantiated twice (horizontal and vertical).
  - Parameters: VISIBLE, FRONT, SYNC, BACK.
  - Inputs: Clk, Reset, advance.
  - Outputs: count, sync_n, active, at_last.
  - at_last of the horizontal instance gates advance of the vertical instance.
- Divider and frame_start decode live in the top.

## Test plan
- Reset, then free-run with CLK_DIV=2 → pixel_ce pattern 0,1,0,1…; DrawX 0,0,1,1,2,2…; DrawY 0; hs=vs=blank=1.
- Horizontal decode → blank falls as DrawX goes 639→640 and rises at 799→0; hs falls at DrawX=656 and rises at 752; hs low 192 Clk.
- Line wrap → DrawX 799→0 and DrawY n→n+1 on the same edge; DrawY 524→0 on the 525th line.
- Full frame → vs low exactly while DrawY ∈ {490,491} (3200 Clk). frame_start high once per 840000 Clk, only when DrawX=799, DrawY=524, pixel_ce=1.
- Reset asserted for one Clk at DrawX=300, DrawY=200 → next edge DrawX=0, DrawY=0, hs=vs=blank=1, pixel_ce=0; no frame_start until 840000 Clk later.
- CLK_DIV=1 override → pixel_ce constantly 1, DrawX increments every Clk, frame period 420000 Clk.
